wfg_capture_spi: RTL

SPI peripheral-side receiver for the waveform generator: samples an external SCLK/CS/SDI bus that is asynchronous to the system clock and deserializes 8/16/24/32-bit words. Each word is emitted on an AXI-stream master port. It is the receiving end of the `wfg_drive_spi` serial format: same CPOL, bit-order, frame-size and slave-select-polarity configuration fields. It is used for loopback verification of the drive path and for capturing stimulus from external hosts.

---
 rtl/wfg_capture_spi.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wfg_capture_spi.sv
// SPI peripheral-side receiver: oversamples an asynchronous SCLK/CS/SDI bus and emits 8..32-bit words on AXI-stream.
// Optional dropped-word counter enabled by defining WFG_CAPTURE_SPI_OVERFLOW_CNT_EN.
module wfg_capture_spi #(
   parameter int AXIS_DATA_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       spi_sclk_i,
   input  logic                       spi_cs_i,
   input  logic                       spi_sdi_i,
   input  logic                       ctrl_en_q_i,
   input  logic                       cfg_cpol_q_i,
   input  logic                       cfg_lsbfirst_q_i,
   input  logic [1:0]                 cfg_dff_q_i,
   input  logic                       cfg_sspol_q_i,
   input  logic                       status_clr_i,
   output logic                       wfg_axis_tvalid_o,
   input  logic                       wfg_axis_tready_i,
   output logic                       wfg_axis_tlast_o,
   output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
   output logic                       err_frame_o,
   output logic                       err_overflow_o,
   output logic [7:0]                 overflow_cnt_o
);

   typedef enum logic [1:0] {
      ST_WAIT_CS_OFF = 2'd0,
      ST_IDLE        = 2'd1,
      ST_SHIFT       = 2'd2
   } state_t;

   state_t state;

   logic [1:0] sclk_ff, cs_ff, sdi_ff;
   logic       sclk_h, cs_h, en_h;
   logic       cpol_r, lsb_r, sspol_r;
   logic [1:0] dff_r;
   logic [4:0] cnt;
   logic [AXIS_DATA_WIDTH-1:0] sr;

   logic                       tvalid_r;
   logic [AXIS_DATA_WIDTH-1:0] tdata_r;
   logic                       err_frame_r, err_ovf_r;

   logic       cur_cpol, cur_sspol, run;
   logic       sample, cs_act, cs_act_h;
   logic [4:0] last_idx;
   logic [AXIS_DATA_WIDTH-1:0] word_next;
   logic       push, frame_err, handshake, drop;

   // Config is tracked live while idle so the start edge uses the new polarity.
   assign cur_cpol  = (state == ST_IDLE) ? cfg_cpol_q_i  : cpol_r;
   assign cur_sspol = (state == ST_IDLE) ? cfg_sspol_q_i : sspol_r;
   assign run       = ctrl_en_q_i & en_h;

   assign sample    = (sclk_ff[1] ^ cur_cpol) & ~(sclk_h ^ cur_cpol);
   assign cs_act    = cur_sspol ? cs_ff[1] : ~cs_ff[1];
   assign cs_act_h  = cur_sspol ? cs_h     : ~cs_h;
   assign last_idx  = {dff_r, 3'b111};
   assign word_next = lsb_r ? (sr | (AXIS_DATA_WIDTH'(sdi_ff[1]) << cnt))
                            : {sr[AXIS_DATA_WIDTH-2:0], sdi_ff[1]};

   assign push      = run && (state == ST_SHIFT) && cs_act && sample && (cnt == last_idx);
   assign frame_err = run && (state == ST_SHIFT) && !cs_act && (cnt != 5'd0);
   assign handshake = tvalid_r & wfg_axis_tready_i;
   assign drop      = push & tvalid_r & ~wfg_axis_tready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_ff <= '0;
         cs_ff   <= '0;
         sdi_ff  <= '0;
         sclk_h  <= 1'b0;
         cs_h    <= 1'b0;
         en_h    <= 1'b0;
      end else begin
         sclk_ff <= {sclk_ff[0], spi_sclk_i};
         cs_ff   <= {cs_ff[0], spi_cs_i};
         sdi_ff  <= {sdi_ff[0], spi_sdi_i};
         sclk_h  <= sclk_ff[1];
         cs_h    <= cs_ff[1];
         en_h    <= ctrl_en_q_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_WAIT_CS_OFF;
         cnt     <= '0;
         sr      <= '0;
         cpol_r  <= 1'b0;
         lsb_r   <= 1'b0;
         sspol_r <= 1'b0;
         dff_r   <= 2'd0;
      end else begin
         if (state == ST_IDLE) begin
            cpol_r  <= cfg_cpol_q_i;
            lsb_r   <= cfg_lsbfirst_q_i;
            sspol_r <= cfg_sspol_q_i;
            dff_r   <= cfg_dff_q_i;
         end
         // Disabled, or just enabled: never join a frame already in progress.
         if (!run) begin
            state <= ST_WAIT_CS_OFF;
         end else begin
            case (state)
               ST_WAIT_CS_OFF: begin
                  if (!cs_act) state <= ST_IDLE;
               end
               ST_IDLE: begin
                  if (cs_act && !cs_act_h) begin
                     state <= ST_SHIFT;
                     cnt   <= '0;
                     sr    <= '0;
                  end
               end
               ST_SHIFT: begin
                  if (!cs_act) begin
                     state <= ST_IDLE;
                  end else if (sample) begin
                     if (cnt == last_idx) begin
                        cnt <= '0;
                        sr  <= '0;
                     end else begin
                        cnt <= cnt + 5'd1;
                        sr  <= word_next;
                     end
                  end
               end
               default: state <= ST_WAIT_CS_OFF;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tvalid_r    <= 1'b0;
         tdata_r     <= '0;
         err_frame_r <= 1'b0;
         err_ovf_r   <= 1'b0;
      end else begin
         if (push && (!tvalid_r || wfg_axis_tready_i)) begin
            tvalid_r <= 1'b1;
            tdata_r  <= word_next;
         end else if (handshake) begin
            tvalid_r <= 1'b0;
         end
         err_frame_r <= frame_err | (err_frame_r & ~status_clr_i);
         err_ovf_r   <= drop | (err_ovf_r & ~status_clr_i);
      end
   end

`ifdef WFG_CAPTURE_SPI_OVERFLOW_CNT_EN
   logic [7:0] ovf_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt <= 8'd0;
      end else if (drop) begin
         if (status_clr_i)          ovf_cnt <= 8'd1;
         else if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      end else if (status_clr_i) begin
         ovf_cnt <= 8'd0;
      end
   end

   assign overflow_cnt_o = ovf_cnt;
`else
   assign overflow_cnt_o = 8'd0;
`endif

   assign wfg_axis_tvalid_o = tvalid_r;
   assign wfg_axis_tlast_o  = tvalid_r;
   assign wfg_axis_tdata_o  = tdata_r;
   assign err_frame_o       = err_frame_r;
   assign err_overflow_o    = err_ovf_r;

endmodule
